// File: rtl/booth_divider.sv
`default_nettype none
// ============================================================================
// Module      : booth_divider
// Description : Sequential signed divider for a 2N-bit dividend and an N-bit
//               divisor. It runs a restoring shift-subtract loop on the
//               operand magnitudes and retires one quotient bit per clock.
//               The result is truncated toward zero, and the remainder takes
//               the sign of the dividend. Both sides use a valid/ready
//               handshake.
//               Optional macro BOOTH_DIV_SAT_EN: when it is defined, an
//               overflowing quotient saturates. When it is not defined, the
//               quotient wraps to its low N bits.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_divider #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             div_zero,
    output logic             overflow
);

    localparam int            c_CW   = $clog2(2*N);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(2*N-1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DIV  = 2'd1;
    localparam logic [1:0] c_SIGN = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_count;
    logic             r_dvd_neg;
    logic             r_dvs_neg;
    logic [2*N-1:0]   r_dvd_sh;     // dividend magnitude, shifted out MSB first
    logic [N-1:0]     r_dvs_mag;
    logic [N-1:0]     r_part;       // partial remainder, always < |divisor|
    logic [2*N-1:0]   r_q;          // quotient magnitude
    logic [N-1:0]     r_quotient;
    logic [N-1:0]     r_remainder;
    logic             r_div_zero;
    logic             r_overflow;
    logic             r_out_valid;

    // Operand magnitudes. A 2N-bit unsigned value already holds 2^(2N-1),
    // so the most negative dividend needs no extra bit.
    logic [2*N-1:0]   w_dvd_mag;
    logic [N-1:0]     w_dvs_mag;
    assign w_dvd_mag = dividend[2*N-1] ? -dividend : dividend;
    assign w_dvs_mag = divisor[N-1]    ? -divisor  : divisor;

    // One restoring step. The trial value is at most 2|divisor|-1, so it
    // fits in N+1 bits, and the difference fits back into N bits.
    logic [N:0]       w_trial;
    logic             w_ge;
    logic [N-1:0]     w_diff;
    logic [N-1:0]     w_part_nxt;
    assign w_trial    = {r_part, r_dvd_sh[2*N-1]};
    assign w_ge       = (w_trial >= {1'b0, r_dvs_mag});
    assign w_diff     = w_trial[N-1:0] - r_dvs_mag;
    assign w_part_nxt = w_ge ? w_diff : w_trial[N-1:0];

    // Sign restoration. The quotient is widened by one bit so that
    // +2^(2N-1) (e.g. -2^(2N-1) / -1) stays distinguishable.
    logic [2*N:0]     w_q_ext;
    logic [2*N:0]     w_q_true;
    logic             w_fits;
    logic [N-1:0]     w_q_out;
    logic [N-1:0]     w_r_out;
    assign w_q_ext  = {1'b0, r_q};
    assign w_q_true = (r_dvd_neg ^ r_dvs_neg) ? -w_q_ext : w_q_ext;
    assign w_fits   = (w_q_true[2*N:N-1] == '0) || (w_q_true[2*N:N-1] == '1);
    assign w_r_out  = r_dvd_neg ? -r_part : r_part;

`ifdef BOOTH_DIV_SAT_EN
    // Clamp to the nearest representable N-bit value on overflow.
    always_comb begin
        w_q_out = w_q_true[N-1:0];
        if (!w_fits) begin
            w_q_out = w_q_true[2*N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end
`else
    assign w_q_out = w_q_true[N-1:0];
`endif

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = r_out_valid;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;
    assign overflow  = r_overflow;

    // Control FSM, divide datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_count     <= '0;
            r_dvd_neg   <= 1'b0;
            r_dvs_neg   <= 1'b0;
            r_dvd_sh    <= '0;
            r_dvs_mag   <= '0;
            r_part      <= '0;
            r_q         <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_dvd_neg <= dividend[2*N-1];
                        r_dvs_neg <= divisor[N-1];
                        r_dvd_sh  <= w_dvd_mag;
                        r_dvs_mag <= w_dvs_mag;
                        if (divisor == '0) begin
                            r_quotient  <= '0;
                            r_remainder <= dividend[N-1:0];
                            r_div_zero  <= 1'b1;
                            r_overflow  <= 1'b0;
                            r_state     <= c_DONE;
                        end else begin
                            r_q     <= '0;
                            r_part  <= '0;
                            r_count <= '0;
                            r_state <= c_DIV;
                        end
                    end
                end
                c_DIV: begin
                    r_part   <= w_part_nxt;
                    r_q      <= {r_q[2*N-2:0], w_ge};
                    r_dvd_sh <= {r_dvd_sh[2*N-2:0], 1'b0};
                    if (r_count == c_LAST) begin
                        r_state <= c_SIGN;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                c_SIGN: begin
                    r_quotient  <= w_q_out;
                    r_remainder <= w_r_out;
                    r_div_zero  <= 1'b0;
                    r_overflow  <= ~w_fits;
                    r_state     <= c_DONE;
                end
                default: begin
                    // DONE: raise valid one cycle after entry, then hold it
                    // until the consumer takes the result.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_divider
// Description : Directed self-checking bench for booth_divider (N=4). The
//               driver pushes the expected results into a queue, and a
//               monitor pops them and compares them on each output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;
    logic       overflow;

`ifdef BOOTH_DIV_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;

    booth_divider #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Monitor: compare every accepted result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result q=%h r=%h dz=%b ovf=%b", quotient, remainder, div_zero, overflow);
            end else begin
                m_e = sb.pop_front();
                if ({quotient, remainder, div_zero, overflow} !== m_e) begin
                    errors++;
                    $display("FAIL result got q=%h r=%h dz=%b ovf=%b want q=%h r=%h dz=%b ovf=%b",
                             quotient, remainder, div_zero, overflow, m_e.q, m_e.r, m_e.dz, m_e.ovf);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er,
                         input logic edz, input logic eovf,
                         input int lat, input string name);
        int cnt;
        wait_ready(name);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        sb.push_back('{q: eq, r: er, dz: edz, ovf: eovf});
        @(posedge clk);
        #1 in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check({name, "_latency"}, cnt, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_q_r", {24'd0, quotient, remainder}, 32'd0);
        check("rst_flags", {30'd0, div_zero, overflow}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        do_op(8'd35,          4'd5,  4'd7,  4'd0, 1'b0, 1'b0, 10, "35_div_5");
        do_op(-8'sd21,        4'd4,  4'hB,  4'hF, 1'b0, 1'b0, 10, "m21_div_4");
        do_op(8'd21,          4'hC,  4'hB,  4'd1, 1'b0, 1'b0, 10, "21_div_m4");
        do_op(-8'sd21,        4'hC,  4'd5,  4'hF, 1'b0, 1'b0, 10, "m21_div_m4");
        do_op(-8'sd64,        4'h8,  SAT ? 4'd7 : 4'h8, 4'd0, 1'b0, 1'b1, 10, "m64_div_m8");
        do_op(8'h80,          4'hF,  SAT ? 4'd7 : 4'd0, 4'd0, 1'b0, 1'b1, 10, "m128_div_m1");
        do_op(8'h80,          4'd1,  SAT ? 4'h8 : 4'd0, 4'd0, 1'b0, 1'b1, 10, "m128_div_1");
        do_op(8'd100,         4'd0,  4'd0,  4'd4, 1'b1, 1'b0, 1,  "100_div_0");
        do_op(8'd0,           4'd3,  4'd0,  4'd0, 1'b0, 1'b0, 10, "0_div_3");

        // Back-pressure: hold out_ready low, and offer a new operation while busy.
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        do_op(8'd15, 4'h8, 4'hF, 4'd7, 1'b0, 1'b0, 10, "15_div_m8");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            dividend = 8'd1;
            divisor  = 4'd1;
            in_valid = 1'b1;
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_q_r", {24'd0, quotient, remainder}, {24'd0, 4'hF, 4'd7});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset in the middle of a division discards it.
        wait_ready("abort");
        dividend = 8'd35;
        divisor  = 4'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_q_r", {24'd0, quotient, remainder}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        do_op(8'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0, 10, "7_div_2");

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
